serial_word_tx: RTL and testbench

- Upstream stage for the serial sequence detectors: a parallel-to-serial shifter that drives their `w` input, one bit per clock.
- Accepts WIDTH-bit words through a valid/ready handshake.
- Emits each word on a registered serial line, with a bit-valid strobe and a last-bit marker.
- Back-to-back words stream with no bubble, so patterns that span word boundaries reach the detector intact.

---
 rtl/serial_word_tx.sv | 156 +++++++++++++++
 tb/tb_serial_word_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial shifter feeding a bit-serial detector.
// Words arrive on a valid/ready handshake and leave one bit per clock on a
// registered line. A word accepted during the final bit of the previous one
// streams with no idle cycle between them. An optional fixed idle gap can
// follow every word.
module serial_word_tx #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b1,
   parameter int GAP        = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             w,
   output logic             w_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam bit              NO_GAP   = (GAP == 0);
   localparam int              GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [7:0]      GAP_LOAD = 8'(GAP_M1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [7:0]       gapcnt_q, gapcnt_d;
   logic             w_q, w_d;
   logic             w_valid_q, w_valid_d;
   logic             last_bit_q, last_bit_d;
   logic             accept;

   // First bit of a freshly presented word.
   function automatic logic first_bit(input logic [WIDTH-1:0] d);
      if (MSB_FIRST) first_bit = d[WIDTH-1];
      else           first_bit = d[0];
   endfunction

   // Bit that follows the one currently on w. The register still holds the
   // bit on w at its head, so the next one sits one position in.
   function automatic logic next_bit(input logic [WIDTH-1:0] s);
      if (MSB_FIRST) next_bit = s[WIDTH-2];
      else           next_bit = s[1];
   endfunction

   // Advance the register by one position, filling the vacated end with 0.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
      if (MSB_FIRST) shift_once = {s[WIDTH-2:0], 1'b0};
      else           shift_once = {1'b0, s[WIDTH-1:1]};
   endfunction

   // A new word may enter from IDLE, or during the final bit when no gap follows.
   assign din_ready = (state_q == S_IDLE) ||
                      ((state_q == S_SHIFT) && (bitcnt_q == '0) && NO_GAP);
   assign accept    = din_valid && din_ready;

   // Next-state and registered-output logic for the shifter FSM.
   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      bitcnt_d   = bitcnt_q;
      gapcnt_d   = gapcnt_q;
      w_d        = w_q;
      w_valid_d  = w_valid_q;
      last_bit_d = last_bit_q;

      if (accept) begin
         // Load a new word; its first bit goes straight onto w.
         state_d    = S_SHIFT;
         sreg_d     = din;
         bitcnt_d   = CNT_LOAD;
         w_d        = first_bit(din);
         w_valid_d  = 1'b1;
         last_bit_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               w_d        = IDLE_LEVEL;
               w_valid_d  = 1'b0;
               last_bit_d = 1'b0;
            end
            S_SHIFT: begin
               if (bitcnt_q != '0) begin
                  sreg_d     = shift_once(sreg_q);
                  w_d        = next_bit(sreg_q);
                  bitcnt_d   = bitcnt_q - CNT_ONE;
                  last_bit_d = (bitcnt_q == CNT_ONE);
               end else begin
                  // Final bit was on w and nothing follows immediately.
                  state_d    = NO_GAP ? S_IDLE : S_GAP;
                  gapcnt_d   = NO_GAP ? gapcnt_q : GAP_LOAD;
                  w_d        = IDLE_LEVEL;
                  w_valid_d  = 1'b0;
                  last_bit_d = 1'b0;
               end
            end
            S_GAP: begin
               w_d        = IDLE_LEVEL;
               w_valid_d  = 1'b0;
               last_bit_d = 1'b0;
               if (gapcnt_q == 8'd0) state_d  = S_IDLE;
               else                  gapcnt_d = gapcnt_q - 8'd1;
            end
            default: begin
               // Unreachable encoding: fall back to the reset condition.
               state_d    = S_IDLE;
               sreg_d     = '0;
               bitcnt_d   = '0;
               gapcnt_d   = 8'd0;
               w_d        = IDLE_LEVEL;
               w_valid_d  = 1'b0;
               last_bit_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sreg_q     <= '0;
         bitcnt_q   <= '0;
         gapcnt_q   <= 8'd0;
         w_q        <= IDLE_LEVEL;
         w_valid_q  <= 1'b0;
         last_bit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         bitcnt_q   <= bitcnt_d;
         gapcnt_q   <= gapcnt_d;
         w_q        <= w_d;
         w_valid_q  <= w_valid_d;
         last_bit_q <= last_bit_d;
      end
   end

   assign w        = w_q;
   assign w_valid  = w_valid_q;
   assign last_bit = last_bit_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx: three instances (MSB-first no gap, MSB-first
// with a two-cycle gap, LSB-first no gap) share clock and reset. Expected bits
// with their arrival cycle go into a per-instance queue when a word is
// accepted and are popped as the serial line delivers them.
module tb_serial_word_tx;

   typedef struct packed {
      logic [31:0] cyc;
      logic        w;
      logic        last;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [7:0] din [3];
   logic       dv  [3];
   logic       rdy [3];
   logic       wo  [3];
   logic       wv  [3];
   logic       lb  [3];
   logic       bsy [3];

   bit   msb [3] = '{1'b1, 1'b1, 1'b0};
   exp_t sb [3][$];
   exp_t e;
   int   cyc;
   int   nchk;
   int   nerr;
   logic [4:0] hist;
   int   hits;

   serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .GAP(0)) u_dut (
      .clk(clk), .reset(reset), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
      .w(wo[0]), .w_valid(wv[0]), .last_bit(lb[0]), .busy(bsy[0]));

   serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .GAP(2)) u_gap (
      .clk(clk), .reset(reset), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
      .w(wo[1]), .w_valid(wv[1]), .last_bit(lb[1]), .busy(bsy[1]));

   serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP(0)) u_lsb (
      .clk(clk), .reset(reset), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
      .w(wo[2]), .w_valid(wv[2]), .last_bit(lb[2]), .busy(bsy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Present a word on instance d and wait for its acceptance; k is the
   // accepting edge number. Returns 1 ns after that edge.
   task automatic send(input int d, input logic [7:0] word, input bit keep, output int k);
      int n;
      din[d] = word;
      dv[d]  = 1'b1;
      n = 0;
      while (!rdy[d] && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk($sformatf("send_timeout%0d", d), 32'(rdy[d]), 1);
      k = cyc + 1;
      for (int i = 0; i < 8; i++)
         sb[d].push_back('{cyc: 32'(k + i), w: (msb[d] ? word[7-i] : word[i]), last: (i == 7)});
      @(posedge clk);
      #1;
      if (!keep) dv[d] = 1'b0;
   endtask

   task automatic wait_neg(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 0);
   endtask

   // Scoreboard: every valid bit must match the head of the queue, in its cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (wv[d]) begin
            if (sb[d].size() == 0) begin
               chk($sformatf("extra_bit%0d", d), 32'(wv[d]), 0);
            end else begin
               e = sb[d].pop_front();
               chk($sformatf("bit_cycle%0d", d), 32'(cyc), e.cyc);
               chk($sformatf("w%0d", d), 32'(wo[d]), 32'(e.w));
               chk($sformatf("last_bit%0d", d), 32'(lb[d]), 32'(e.last));
            end
         end else if (sb[d].size() != 0 && sb[d][0].cyc == 32'(cyc)) begin
            chk($sformatf("missing_bit%0d", d), 32'(wv[d]), 1);
            void'(sb[d].pop_front());
         end
      end
   end

   // Reference 00110 detector watching the MSB-first line every cycle.
   initial begin
      hist = 5'b11111;
      hits = 0;
   end
   always @(negedge clk) begin
      hist <= {hist[3:0], wo[0]};
      if ({hist[3:0], wo[0]} == 5'b00110) hits <= hits + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, k2;
      nchk  = 0;
      nerr  = 0;
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         din[d] = 8'h00;
         dv[d]  = 1'b0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_w%0d", d), 32'(wo[d]), 1);
         chk($sformatf("rst_wv%0d", d), 32'(wv[d]), 0);
         chk($sformatf("rst_lb%0d", d), 32'(lb[d]), 0);
         chk($sformatf("rst_busy%0d", d), 32'(bsy[d]), 0);
         chk($sformatf("rst_rdy%0d", d), 32'(rdy[d]), 1);
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_w", 32'(wo[0]), 1);
      chk("idle_wv", 32'(wv[0]), 0);

      // Single word 8'h30, MSB first
      send(0, 8'h30, 1'b0, k);
      wait_neg(k + 8);
      chk("t1_idle_w", 32'(wo[0]), 1);
      chk("t1_idle_wv", 32'(wv[0]), 0);
      chk("t1_idle_rdy", 32'(rdy[0]), 1);
      chk("t1_idle_busy", 32'(bsy[0]), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("detector_hits", 32'(hits), 1);

      // Back-to-back 8'hA5, 8'h3C with valid held
      send(0, 8'hA5, 1'b1, k);
      send(0, 8'h3C, 1'b0, k2);
      chk("b2b_accept_edge", 32'(k2 - k), 8);
      drain();

      // GAP=2 instance: 8'hFF then 8'h00
      send(1, 8'hFF, 1'b0, k);
      wait_neg(k + 7);
      chk("gap_rdy_lastbit", 32'(rdy[1]), 0);
      for (int c = 8; c <= 9; c++) begin
         wait_neg(k + c);
         chk("gap_w", 32'(wo[1]), 1);
         chk("gap_wv", 32'(wv[1]), 0);
         chk("gap_rdy", 32'(rdy[1]), 0);
         chk("gap_busy", 32'(bsy[1]), 1);
      end
      wait_neg(k + 10);
      chk("gap_idle_rdy", 32'(rdy[1]), 1);
      chk("gap_idle_wv", 32'(wv[1]), 0);
      send(1, 8'h00, 1'b0, k2);
      chk("gap_accept_edge", 32'(k2 - k), 11);
      drain();

      // LSB-first instance: 8'h01
      send(2, 8'h01, 1'b0, k);
      drain();

      // Reset pulse during bit 4 of 8'hC3
      send(0, 8'hC3, 1'b0, k);
      wait_neg(k + 4);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_w", 32'(wo[0]), 1);
      chk("mid_rst_wv", 32'(wv[0]), 0);
      chk("mid_rst_lb", 32'(lb[0]), 0);
      chk("mid_rst_busy", 32'(bsy[0]), 0);
      for (int d = 0; d < 3; d++) sb[d].delete();
      @(negedge clk);
      #2;
      reset = 1'b1;
      send(0, 8'h0F, 1'b0, k);
      drain();

      // Valid raised mid-word waits for the final bit
      send(0, 8'h5A, 1'b0, k);
      wait_neg(k + 2);
      chk("midword_rdy", 32'(rdy[0]), 0);
      send(0, 8'h96, 1'b0, k2);
      chk("midword_accept_edge", 32'(k2 - k), 8);
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
